// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared op encodings, FSM state type and default widths for
//                the stack memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ptr
//  Description : Stack occupancy counter with increment, decrement and clear,
//                plus combinational full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ptr #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_inc,
    input  logic                  i_dec,
    input  logic                  i_clr,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] r_count;

    // Reset wins over a same-edge increment so an aborted write is never counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + c_ONE;
        end else if (i_dec) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stack_mem_ctrl
//  Description : Sequences push/pop/peek/clear commands into SRAM strobes,
//                tracks the stack pointer and returns a one-cycle response.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_mem_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  cmd_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  CE,
    output logic                  OE,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] stackData
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_op;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_clr;
    logic                  r_ce;
    logic                  r_oe;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_input_data;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ADDR_WIDTH-1:0] w_top_addr;

    stack_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_stack_ptr (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .i_clr   (w_clr),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    assign w_accept   = cmd_valid && (r_state == IDLE);
    assign w_top_addr = count[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            w_err       = full;
                            w_state_nxt = full ? RESP : WR;
                        end
                        OP_POP, OP_PEEK: begin
                            w_err       = empty;
                            w_state_nxt = empty ? RESP : RD;
                        end
                        default: begin
                            w_clr       = 1'b1;
                            w_state_nxt = RESP;
                        end
                    endcase
                end
            end
            WR: begin
                w_inc       = 1'b1;
                w_state_nxt = RESP;
            end
            RD: begin
                w_dec       = (r_op == OP_POP);
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free
    // during WR/RD and drop on the same edge a reset lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= OP_PUSH;
            r_ce         <= 1'b1;
            r_oe         <= 1'b1;
            r_we         <= 1'b0;
            r_address    <= '0;
            r_input_data <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_ce <= !((w_state_nxt == WR) || (w_state_nxt == RD));
            r_oe <= !(w_state_nxt == RD);
            r_we <= (w_state_nxt == WR);
            if (w_accept) begin
                r_op       <= cmd_op;
                r_rsp_err  <= w_err;
                r_rsp_data <= '0;
                if (w_state_nxt == WR) begin
                    r_address    <= count[ADDR_WIDTH-1:0];
                    r_input_data <= cmd_data;
                end else if (w_state_nxt == RD) begin
                    r_address <= w_top_addr;
                end
            end
            if (r_state == RD_WAIT) begin
                r_rsp_data <= stackData;
            end
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_err    = r_rsp_err;
    assign rsp_data   = r_rsp_data;
    assign CE         = r_ce;
    assign OE         = r_oe;
    assign WE         = r_we;
    assign address    = r_address;
    assign input_data = r_input_data;

endmodule
`default_nettype wire

// File: tb/tb_stack_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_mem_ctrl
//  Description : Scoreboard bench for stack_mem_ctrl with a behavioural SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_ready, rsp_valid, rsp_err, full, empty, CE, OE, WE;
    logic [DW-1:0] rsp_data, input_data;
    logic [DW-1:0] stackData = '0;
    logic [AW:0]   count;
    logic [AW-1:0] address;

    stack_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .count(count), .full(full),
        .empty(empty), .CE(CE), .OE(OE), .WE(WE), .address(address),
        .input_data(input_data), .stackData(stackData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [AW-1:0] rd_addr_log[$];
    int            ce_cnt = 0;
    int            cyc = 0;
    int            n_total = 0;
    int            n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (!CE && WE) mem[address] <= input_data;
        if (!CE && !OE) stackData <= mem[address];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (!CE) ce_cnt++;
            if (!CE && WE) begin
                wr_addr_log.push_back(address);
                wr_data_log.push_back(input_data);
            end
            if (!CE && !OE) rd_addr_log.push_back(address);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
                    check_eq("rsp_data", 64'(rsp_data), 64'(e.data));
                    check_eq("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
        end
    end

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        ce_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        clear_logs();
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] d,
                          input logic e_err, input logic [DW-1:0] e_data, input int e_lat);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) check_eq("ready_timeout", 64'(0), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        e.err = e_err; e.data = e_data; e.lat = e_lat; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !cmd_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0 || !cmd_ready) check_eq("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("rst_strobes", 64'({CE, OE, WE}), 64'(3'b110));
        check_eq("rst_addr", 64'(address), 64'(0));
        check_eq("rst_wdata", 64'(input_data), 64'(0));
        check_eq("rst_flags", 64'({cmd_ready, rsp_valid, rsp_err, empty, full}), 64'(5'b10010));
        check_eq("rst_rdata", 64'(rsp_data), 64'(0));
        reset = 1'b0;
        clear_logs();

        // Single push
        do_cmd(2'b00, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        drain();
        check_eq("push_we_pulses", 64'(wr_addr_log.size()), 64'(1));
        if (wr_addr_log.size() == 1) begin
            check_eq("push_addr", 64'(wr_addr_log[0]), 64'(0));
            check_eq("push_wdata", 64'(wr_data_log[0]), 64'(32'hDEADBEEF));
        end
        check_eq("push_count", 64'(count), 64'(1));
        check_eq("push_empty", 64'(empty), 64'(0));

        // LIFO order, pop then peek
        do_reset();
        do_cmd(2'b00, 32'h11, 1'b0, 32'h0, 2);
        do_cmd(2'b00, 32'h22, 1'b0, 32'h0, 2);
        do_cmd(2'b00, 32'h33, 1'b0, 32'h0, 2);
        do_cmd(2'b01, 32'h0, 1'b0, 32'h33, 3);
        drain();
        check_eq("pop_count", 64'(count), 64'(2));
        clear_logs();
        do_cmd(2'b10, 32'h0, 1'b0, 32'h22, 3);
        drain();
        check_eq("peek_count", 64'(count), 64'(2));
        check_eq("peek_rd_strobes", 64'(rd_addr_log.size()), 64'(1));
        if (rd_addr_log.size() == 1) check_eq("peek_addr", 64'(rd_addr_log[0]), 64'(1));

        // Underflow
        do_reset();
        do_cmd(2'b01, 32'h0, 1'b1, 32'h0, 1);
        drain();
        check_eq("underflow_ce", 64'(ce_cnt), 64'(0));
        check_eq("underflow_count", 64'(count), 64'(0));

        // Fill to capacity, overflow, pop top
        do_reset();
        for (int i = 0; i < 1024; i++) do_cmd(2'b00, DW'(i), 1'b0, 32'h0, 2);
        drain();
        check_eq("fill_full", 64'(full), 64'(1));
        check_eq("fill_count", 64'(count), 64'(1024));
        check_eq("fill_last_addr", 64'(wr_addr_log[$]), 64'(1023));
        clear_logs();
        do_cmd(2'b00, 32'hBAD, 1'b1, 32'h0, 1);
        drain();
        check_eq("overflow_no_we", 64'(wr_addr_log.size()), 64'(0));
        check_eq("overflow_count", 64'(count), 64'(1024));
        do_cmd(2'b01, 32'h0, 1'b0, 32'd1023, 3);
        drain();
        check_eq("pop_after_full", 64'(full), 64'(0));

        // Clear
        do_reset();
        for (int i = 0; i < 5; i++) do_cmd(2'b00, DW'(i + 100), 1'b0, 32'h0, 2);
        drain();
        check_eq("pre_clear_count", 64'(count), 64'(5));
        do_cmd(2'b11, 32'h0, 1'b0, 32'h0, 1);
        check_eq("clear_count", 64'(count), 64'(0));
        check_eq("clear_empty", 64'(empty), 64'(1));
        drain();
        do_cmd(2'b01, 32'h0, 1'b1, 32'h0, 1);
        drain();

        // Reset during WR
        do_reset();
        for (int i = 0; i < 3; i++) do_cmd(2'b00, DW'(i + 7), 1'b0, 32'h0, 2);
        drain();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 32'hCAFE;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("wr_we", 64'({CE, WE}), 64'(2'b01));
        check_eq("wr_addr", 64'(address), 64'(3));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_count", 64'(count), 64'(0));
        check_eq("abort_strobes", 64'({CE, WE}), 64'(2'b10));
        check_eq("abort_rsp", 64'(rsp_valid), 64'(0));
        check_eq("abort_ready", 64'(cmd_ready), 64'(1));
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_rsp", 64'(rsp_valid), 64'(0));
        end
        check_eq("sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
